// File: rtl/jtmx5k_pkg.sv
// jtmx5k_pkg: definitions shared by the sound command port.
//   state_t      - 3-bit encoding of the command hand-off state machine
//   jtmx_clog2() - ceiling log2, used to size pointers and counters
package jtmx5k_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_IRQ     = 3'd2,
        ST_WAIT_RD = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // Returns 0 for values <= 1.
    function automatic int jtmx_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtmx5k_cmdfifo.sv
// jtmx5k_cmdfifo: DEPTH x 8 circular command buffer.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push_i       - write request (dropped when full unless a pop happens in the same cycle)
//   din_i        - byte to write
//   pop_i        - consume the head entry
//   head_o       - current head entry
//   full_o       - DEPTH entries held
//   empty_o      - no entries held
//   overflow_o   - sticky, a push was dropped; cleared only by reset
module jtmx5k_cmdfifo
    import jtmx5k_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       overflow_o
);

    localparam int PW = jtmx_clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          do_push, do_pop;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign overflow_o = ovf_q;
    assign head_o     = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (push_i & ~do_push) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset: emptiness is defined by the count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/jtmx5k_sndcmd.sv
// jtmx5k_sndcmd: main-CPU side of the sound latch/IRQ link.
// Queues command bytes from the main CPU and hands them one at a time to the
// sound CPU: latch the byte, pulse snd_irq, wait for the latch read (or a
// timeout), idle for GAP cycles, then present the next byte.
// Ports:
//   clk, rst_n  - 24 MHz clock, asynchronous active-low reset
//   main_we     - one-cycle command write strobe (already cen-qualified)
//   main_din    - command byte
//   snd_rd      - sound-CPU latch read level; edge-detected here
//   snd_latch   - byte presented to the sound CPU
//   snd_irq     - IRQ pulse, IRQ_LEN cycles per command
//   fifo_full   - command queue holds DEPTH entries
//   fifo_empty  - command queue is empty
//   overflow    - sticky, a command write was dropped
//   busy        - state machine is not idle
module jtmx5k_sndcmd
    import jtmx5k_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int IRQ_LEN = 64,
    parameter int GAP     = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       main_we,
    input  logic [7:0] main_din,
    input  logic       snd_rd,
    output logic [7:0] snd_latch,
    output logic       snd_irq,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic       busy
);

    localparam int IRQ_W = jtmx_clog2(IRQ_LEN) + 1;
    localparam int GAP_W = jtmx_clog2(GAP) + 1;
    localparam int TO_W  = jtmx_clog2(TIMEOUT) + 1;

    // Terminal counts: each counter is cleared on state entry.
    localparam logic [IRQ_W-1:0] IRQ_LAST = IRQ_W'(IRQ_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           st_q;
    logic [IRQ_W-1:0] irq_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             rd_q;
    logic             rd_seen_q;
    logic             rd_rise;
    logic             timeout_hit;
    logic             pop;
    logic [7:0]       head;

    jtmx5k_cmdfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (main_we),
        .din_i      (main_din),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign rd_rise     = snd_rd & ~rd_q;
    assign pop         = (st_q == ST_LOAD);
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);
    assign busy        = (st_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_IDLE;
            snd_latch <= 8'h00;
            snd_irq   <= 1'b0;
            irq_cnt_q <= '0;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
            rd_q      <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            rd_q <= snd_rd;
            case (st_q)
                ST_IDLE: begin
                    if (!fifo_empty) st_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    snd_latch <= head;
                    irq_cnt_q <= '0;
                    rd_seen_q <= 1'b0;
                    st_q      <= ST_IRQ;
                end
                ST_IRQ: begin
                    // A read that arrives while the IRQ is still high must not be lost.
                    if (rd_rise) rd_seen_q <= 1'b1;
                    if (irq_cnt_q == IRQ_LAST) begin
                        snd_irq  <= 1'b0;
                        to_cnt_q <= '0;
                        st_q     <= ST_WAIT_RD;
                    end else begin
                        // Raised one cycle after the latch update so data leads the edge.
                        snd_irq   <= 1'b1;
                        irq_cnt_q <= irq_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    if (rd_seen_q || rd_rise || timeout_hit) begin
                        gap_cnt_q <= '0;
                        st_q      <= ST_GAP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) st_q <= ST_IDLE;
                    else                       gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtmx5k_sndcmd.sv
module tb_jtmx5k_sndcmd;

    localparam int DEPTH   = 4;
    localparam int IRQ_LEN = 64;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 100;

    logic       clk;
    logic       rst_n;
    logic       main_we;
    logic [7:0] main_din;
    logic       snd_rd;

    logic [7:0] u1_latch, u2_latch;
    logic       u1_irq, u1_full, u1_empty, u1_ovf, u1_busy;
    logic       u2_irq, u2_full, u2_empty, u2_ovf, u2_busy;

    jtmx5k_sndcmd #(
        .DEPTH(DEPTH), .IRQ_LEN(IRQ_LEN), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .main_we(main_we), .main_din(main_din), .snd_rd(snd_rd),
        .snd_latch(u1_latch), .snd_irq(u1_irq), .fifo_full(u1_full), .fifo_empty(u1_empty),
        .overflow(u1_ovf), .busy(u1_busy)
    );

    // Same traffic, but never gives up waiting for the read.
    jtmx5k_sndcmd #(
        .DEPTH(DEPTH), .IRQ_LEN(IRQ_LEN), .GAP(GAP), .TIMEOUT(0)
    ) dut_nto (
        .clk(clk), .rst_n(rst_n), .main_we(main_we), .main_din(main_din), .snd_rd(snd_rd),
        .snd_latch(u2_latch), .snd_irq(u2_irq), .fifo_full(u2_full), .fifo_empty(u2_empty),
        .overflow(u2_ovf), .busy(u2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of bytes plus the edge numbers at which each
    // command is popped, released and the block next becomes idle.
    logic [7:0] mq[$];
    logic [7:0] m_latch;
    int  n;          // edge index
    int  pop_e;      // scheduled pop edge, -1 if none
    int  last_pop;   // edge of the most recent pop
    int  w_e;        // edge at which the IRQ pulse ends (wait-for-read begins)
    int  idle_e;     // edge after which the block is idle again
    bit  running, seen, m_ovf, rd_prev;

    task automatic model_reset();
        mq.delete();
        m_latch  = 8'h00;
        n        = 0;
        pop_e    = -1;
        last_pop = -100000;
        w_e      = 0;
        idle_e   = -1;
        running  = 1'b0;
        seen     = 1'b0;
        m_ovf    = 1'b0;
        rd_prev  = 1'b0;
    endtask

    task automatic model_edge(input bit we, input logic [7:0] din, input bit rd);
        bit rr;
        n++;
        rr = rd && !rd_prev;
        rd_prev = rd;
        if (pop_e == n) begin
            m_latch  = mq.pop_front();
            last_pop = n;
            w_e      = n + IRQ_LEN + 1;
            running  = 1'b1;
            seen     = 1'b0;
            pop_e    = -1;
        end else if (running) begin
            if (n <= w_e) begin
                if (rr) seen = 1'b1;
            end else if (seen || rr || (TIMEOUT != 0 && n == w_e + TIMEOUT)) begin
                running = 1'b0;
                idle_e  = n + GAP;
            end
        end
        if (we) begin
            if (mq.size() < DEPTH) mq.push_back(din);
            else                   m_ovf = 1'b1;
        end
        if (!running && pop_e < 0 && n >= idle_e && mq.size() > 0) pop_e = n + 2;
    endtask

    task automatic cmp_model();
        bit e_irq, e_busy;
        e_irq  = (n >= last_pop + 1) && (n <= last_pop + IRQ_LEN);
        e_busy = running || (n < idle_e) || (pop_e >= 0 && n >= pop_e - 1);
        chk("latch", u1_latch, m_latch);
        chk("irq",   u1_irq,   e_irq);
        chk("busy",  u1_busy,  e_busy);
        chk("full",  u1_full,  mq.size() == DEPTH);
        chk("empty", u1_empty, mq.size() == 0);
        chk("ovf",   u1_ovf,   m_ovf);
    endtask

    // Called at a negedge: drive, clock, step the model, compare at the next negedge.
    task automatic cycle(input bit we, input logic [7:0] din, input bit rd);
        main_we  = we;
        main_din = din;
        snd_rd   = rd;
        @(posedge clk);
        model_edge(we, din, rd);
        @(negedge clk);
        cmp_model();
        main_we = 1'b0;
    endtask

    task automatic idle(input int k, input bit rd);
        for (int i = 0; i < k; i++) cycle(1'b0, 8'h00, rd);
    endtask

    task automatic wait_irq(input bit level, input bit rd, input string tag);
        int k;
        k = 0;
        while (u1_irq !== level && k < 400) begin
            cycle(1'b0, 8'h00, rd);
            k++;
        end
        chk(tag, u1_irq, level);
    endtask

    task automatic consume(input logic [7:0] exp_b, input string tag);
        wait_irq(1'b1, 1'b0, {tag, "_irq_on"});
        chk(tag, u1_latch, exp_b);
        wait_irq(1'b0, 1'b0, {tag, "_irq_off"});
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        main_we  = 1'b0;
        main_din = 8'h00;
        snd_rd   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_latch", u1_latch, 8'h00);
        chk("rst_irq",   u1_irq,   1'b0);
        chk("rst_busy",  u1_busy,  1'b0);
        chk("rst_empty", u1_empty, 1'b1);
        chk("rst_full",  u1_full,  1'b0);
        chk("rst_ovf",   u1_ovf,   1'b0);
        chk("rst_busy2", u2_busy,  1'b0);
        model_reset();
        rst_n = 1'b1;
    endtask

    int rd_len;
    int k;
    bit r_we, r_rd;
    logic [7:0] r_d;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        main_we = 1'b0;
        main_din = 8'h00;
        snd_rd = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write: latch at edge 2, IRQ edges 3..66, busy drops GAP after the read.
        cycle(1'b1, 8'h5A, 1'b0);
        chk("t1_cnt_e0", u1_empty, 1'b0);
        for (int i = 1; i <= 70; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (i == 1)  chk("t1_busy_e1", u1_busy, 1'b1);
            if (i == 2)  begin chk("t1_latch_e2", u1_latch, 8'h5A); chk("t1_irq_e2", u1_irq, 1'b0); end
            if (i == 3)  chk("t1_irq_e3", u1_irq, 1'b1);
            if (i == 66) chk("t1_irq_e66", u1_irq, 1'b1);
            if (i == 67) chk("t1_irq_e67", u1_irq, 1'b0);
        end
        for (int j = 0; j <= 17; j++) begin
            cycle(1'b0, 8'h00, j < 3);
            if (j == 15) chk("t1_busy_r15", u1_busy, 1'b1);
            if (j == 16) chk("t1_busy_r16", u1_busy, 1'b0);
        end
        chk("t1_latch_hold", u1_latch, 8'h5A);

        // Burst of five into a four-deep queue while idle.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("t2_ovf", u1_ovf, 1'b0);
        for (int i = 1; i <= 5; i++) consume(8'(i), "t2_byte");
        idle(40, 1'b0);
        chk("t2_ovf_end", u1_ovf, 1'b0);

        // Overflow while parked in wait-for-read.
        cycle(1'b1, 8'hA0, 1'b0);
        wait_irq(1'b1, 1'b0, "t3_a0_on");
        wait_irq(1'b0, 1'b0, "t3_a0_off");
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
            if (i == 4) begin chk("t3_full4", u1_full, 1'b1); chk("t3_ovf4", u1_ovf, 1'b0); end
            if (i == 5) chk("t3_ovf5", u1_ovf, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) consume(8'hB0 + 8'(i), "t3_byte");
        idle(60, 1'b0);
        chk("t3_empty", u1_empty, 1'b1);
        chk("t3_latch", u1_latch, 8'hB4);

        // Timeout: the second byte loads TIMEOUT + GAP + 2 edges after the IRQ ends.
        do_reset();
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        wait_irq(1'b1, 1'b0, "t4_on");
        wait_irq(1'b0, 1'b0, "t4_off");
        k = 0;
        while (u1_latch !== 8'h3C && k < 400) begin
            cycle(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("t4_load_delay", k, TIMEOUT + GAP + 2);
        chk("t4_nto_latch", u2_latch, 8'hC3);
        chk("t4_nto_busy",  u2_busy,  1'b1);
        idle(250, 1'b0);
        chk("t4_nto_latch2", u2_latch, 8'hC3);
        chk("t4_nto_busy2",  u2_busy,  1'b1);
        chk("t4_nto_empty",  u2_empty, 1'b0);
        chk("t4_nto_irq",    u2_irq,   1'b0);

        // Read held high from the IRQ phase on: one consume, one-cycle wait.
        do_reset();
        cycle(1'b1, 8'h77, 1'b0);
        wait_irq(1'b1, 1'b0, "t5_on");
        wait_irq(1'b0, 1'b1, "t5_off");
        for (int j = 1; j <= 17; j++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (j == 16) chk("t5_busy16", u1_busy, 1'b1);
            if (j == 17) chk("t5_busy17", u1_busy, 1'b0);
        end
        cycle(1'b1, 8'h88, 1'b1);
        wait_irq(1'b1, 1'b1, "t5_88_on");
        wait_irq(1'b0, 1'b1, "t5_88_off");
        idle(50, 1'b1);
        chk("t5_stuck_busy", u1_busy, 1'b1);
        chk("t5_latch88", u1_latch, 8'h88);
        idle(150, 1'b0);

        // Asynchronous reset in the IRQ phase with two bytes queued.
        do_reset();
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        wait_irq(1'b1, 1'b0, "t6_on");
        idle(5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_irq",   u1_irq,   1'b0);
        chk("t6_latch", u1_latch, 8'h00);
        chk("t6_empty", u1_empty, 1'b1);
        chk("t6_busy",  u1_busy,  1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(200, 1'b0);

        // Random traffic against the model.
        do_reset();
        rd_len = 0;
        for (int i = 0; i < 4000; i++) begin
            r_we = ($urandom_range(0, 7) == 0);
            r_d  = 8'($urandom);
            if (rd_len > 0) begin
                r_rd = 1'b1;
                rd_len--;
            end else begin
                r_rd = 1'b0;
                if ($urandom_range(0, 29) == 0) rd_len = $urandom_range(1, 6);
            end
            cycle(r_we, r_d, r_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
